stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 65 ++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to N single-entry output channels,
// with broadcast to all channels and counting of out-of-range selects.
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SELW-1:0]      in_sel,
   input  logic                 in_bcast,
   output logic [N-1:0]         out_valid,
   input  logic [N-1:0]         out_ready,
   output logic [N*WIDTH-1:0]   out_data,
   output logic [7:0]           drop_cnt
);
   logic [N-1:0]     r_full;
   logic [WIDTH-1:0] r_data [N];
   logic [7:0]       r_drop;
   logic [N-1:0]     w_free;
   logic [N-1:0]     w_tgt;
   logic [N-1:0]     w_load;
   logic             w_oor;
   logic             w_acc;

   // Target mask is all ones for broadcast and empty for an out-of-range select.
   always_comb begin
      w_tgt = '0;
      for (int i = 0; i < N; i++) w_tgt[i] = in_bcast | (in_sel == SELW'(i));
   end

   assign w_free   = ~r_full | out_ready;
   assign w_oor    = !in_bcast && (int'(in_sel) >= N);
   assign in_ready = rst_n && (in_bcast ? &w_free : (w_oor || |(w_tgt & w_free)));
   assign w_acc    = in_valid && in_ready;
   assign w_load   = w_acc ? w_tgt : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_full <= '0;
         r_drop <= '0;
         for (int i = 0; i < N; i++) r_data[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_load[i]) begin
               r_full[i] <= 1'b1;
               r_data[i] <= in_data;
            end else if (out_ready[i]) begin
               r_full[i] <= 1'b0;
            end
         end
         if (w_acc && w_oor && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_out
      assign out_data[k*WIDTH +: WIDTH] = r_data[k];
   end

   assign out_valid = r_full;
   assign drop_cnt  = r_drop;
endmodule
